// File: rtl/pin_capture.sv
// Measures high/low phase widths and cycle count of an asynchronous pin via a register map.
// Register reads return one clock after the address is presented; there is no backpressure and writes always complete.
module pin_capture #(
    parameter int POSITION = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [20:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    output logic [15:0] data_out,
    input  logic        pin_in,
    output logic        done
);

    localparam logic [20:0] A_CMD    = 21'd0;
    localparam logic [20:0] A_CYCLES = 21'(POSITION + 4);
    localparam logic [20:0] A_HIGH   = 21'(POSITION + 8);
    localparam logic [20:0] A_LOW    = 21'(POSITION + 12);
    localparam logic [20:0] A_CCOUNT = 21'(POSITION + 16);
    localparam logic [20:0] A_STATUS = 21'(POSITION + 20);

    localparam logic [15:0] CMD_START = 16'd1;
    localparam logic [15:0] CMD_STOP  = 16'd2;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] high_time_q, high_time_d;
    logic [15:0] low_time_q, low_time_d;
    logic [15:0] cycle_count_q, cycle_count_d;
    logic [15:0] cycles_q, cycles_d;
    logic [15:0] cnt_q, cnt_d;
    logic        overflow_q, overflow_d;
    logic        sync1_q, sync2_q, pin_prev_q;
    logic [15:0] data_out_q, data_out_d;

    logic        cmd_start, cmd_stop;
    logic        pin_rise, pin_fall;
    logic        cnt_at_max;
    logic [15:0] cnt_sat;
    logic [15:0] cycle_count_inc;
    logic        running;

    assign cmd_start = wr && (addr == A_CMD) && (data_in == CMD_START);
    assign cmd_stop  = wr && (addr == A_CMD) && (data_in == CMD_STOP);

    // sync2_q is the synchronised pin; pin_prev_q is its one-cycle-old copy
    assign pin_rise = sync2_q & ~pin_prev_q;
    assign pin_fall = ~sync2_q & pin_prev_q;

    assign cnt_at_max      = (cnt_q == CNT_MAX);
    assign cnt_sat         = cnt_at_max ? CNT_MAX : cnt_q + 16'd1;
    assign cycle_count_inc = cycle_count_q + 16'd1;

    assign running  = (state_q == S_ARM) || (state_q == S_HIGH) || (state_q == S_LOW);
    assign done     = (state_q == S_DONE);
    assign data_out = data_out_q;

    always_comb begin
        state_d       = state_q;
        high_time_d   = high_time_q;
        low_time_d    = low_time_q;
        cycle_count_d = cycle_count_q;
        cnt_d         = cnt_q;
        overflow_d    = overflow_q;

        if (cmd_start) begin
            // START from any state re-arms and wipes the previous measurement
            state_d       = S_ARM;
            high_time_d   = 16'd0;
            low_time_d    = 16'd0;
            cycle_count_d = 16'd0;
            cnt_d         = 16'd0;
            overflow_d    = 1'b0;
        end else if (cmd_stop && running) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
        end else begin
            unique case (state_q)
                S_ARM: begin
                    if (pin_rise) begin
                        state_d = S_HIGH;
                        cnt_d   = 16'd1;
                    end
                end
                S_HIGH: begin
                    if (pin_fall) begin
                        high_time_d = cnt_q;
                        cnt_d       = 16'd1;
                        state_d     = S_LOW;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt_at_max) overflow_d = 1'b1;
                    end
                end
                S_LOW: begin
                    if (pin_rise) begin
                        low_time_d    = cnt_q;
                        cycle_count_d = cycle_count_inc;
                        cnt_d         = 16'd1;
                        if ((cycles_q != 16'd0) && (cycle_count_inc == cycles_q))
                            state_d = S_DONE;
                        else
                            state_d = S_HIGH;
                    end else begin
                        cnt_d = cnt_sat;
                        if (cnt_at_max) overflow_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        cycles_d = cycles_q;
        if (wr && (addr == A_CYCLES)) cycles_d = data_in;
    end

    always_comb begin
        data_out_d = 16'd0;
        case (addr)
            A_HIGH:   data_out_d = high_time_q;
            A_LOW:    data_out_d = low_time_q;
            A_CCOUNT: data_out_d = cycle_count_q;
            A_STATUS: data_out_d = {12'd0, overflow_q, running, done, sync2_q};
            default:  data_out_d = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            high_time_q   <= 16'd0;
            low_time_q    <= 16'd0;
            cycle_count_q <= 16'd0;
            cycles_q      <= 16'd0;
            cnt_q         <= 16'd0;
            overflow_q    <= 1'b0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            pin_prev_q    <= 1'b0;
            data_out_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            high_time_q   <= high_time_d;
            low_time_q    <= low_time_d;
            cycle_count_q <= cycle_count_d;
            cycles_q      <= cycles_d;
            cnt_q         <= cnt_d;
            overflow_q    <= overflow_d;
            sync1_q       <= pin_in;
            sync2_q       <= sync1_q;
            pin_prev_q    <= sync2_q;
            data_out_q    <= data_out_d;
        end
    end

endmodule
